// File: rtl/filter_out_capture_pkg.sv
// Shared definitions for the filter-output capture buffer: FSM encoding and default widths.
`timescale 1ns/1ps
package filter_out_capture_pkg;

    localparam int DEFAULT_DATA_W = 24;
    localparam int DEFAULT_ADDR_W = 13;
    localparam int DROP_CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/filter_out_capture_if.sv
// Capture-side and readout-side signals of filter_out_capture, bundled for the top-level port.
`timescale 1ns/1ps
interface filter_out_capture_if
    import filter_out_capture_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic                  start_capture;
    logic [DATA_W-1:0]     data_in;
    logic                  valid_in;
    logic                  busy;
    logic                  capture_done;
    logic                  rd_req;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_valid;
    logic                  rd_last;
    logic [DROP_CNT_W-1:0] drop_cnt;

    modport master (
        output start_capture, data_in, valid_in, rd_req,
        input  busy, capture_done, rd_data, rd_valid, rd_last, drop_cnt
    );

    modport slave (
        input  start_capture, data_in, valid_in, rd_req,
        output busy, capture_done, rd_data, rd_valid, rd_last, drop_cnt
    );
endinterface

// File: rtl/filter_out_capture_capture_dp_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port with 1-cycle latency.
`timescale 1ns/1ps
module capture_dp_ram #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the array has no reset so it maps onto block RAM; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register holds its value between reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/filter_out_capture.sv
// Captures CAPTURE_LEN valid filter samples after a start pulse, then replays them in order on request.
`timescale 1ns/1ps
module filter_out_capture
    import filter_out_capture_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int CAPTURE_LEN = 8192
) (
    input  logic                 clk,
    input  logic                 rst_n,
    filter_out_capture_if.slave  bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CAPTURE_LEN - 1);

    state_t                state;
    logic [ADDR_W-1:0]     wr_addr;
    logic [ADDR_W-1:0]     rd_addr;
    logic                  busy_q;
    logic                  done_q;
    logic                  rd_valid_q;
    logic                  rd_last_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    logic                  wr_en;
    logic                  rd_en;

    // A start pulse in DONE pre-empts a simultaneous read request.
    assign wr_en = (state == ST_CAPTURE) && bus.valid_in;
    assign rd_en = (state == ST_DONE) && bus.rd_req && !bus.start_capture;

    capture_dp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (bus.data_in),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (bus.rd_data)
    );

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wr_addr    <= '0;
            rd_addr    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            rd_valid_q <= rd_en;
            rd_last_q  <= rd_en && (rd_addr == LAST_ADDR);

            if (bus.valid_in && (state != ST_CAPTURE) && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (bus.start_capture) begin
                        state   <= ST_CAPTURE;
                        wr_addr <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (bus.valid_in) begin
                        wr_addr <= wr_addr + ADDR_W'(1);
                        if (wr_addr == LAST_ADDR) begin
                            state   <= ST_DONE;
                            rd_addr <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.start_capture) begin
                        state   <= ST_CAPTURE;
                        wr_addr <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else if (bus.rd_req) begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                        if (rd_addr == LAST_ADDR) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.capture_done = done_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_last      = rd_last_q;
    assign bus.drop_cnt     = drop_cnt_q;
endmodule

// File: tb/tb_filter_out_capture.sv
// Scoreboard bench for filter_out_capture with CAPTURE_LEN=8, ADDR_W=3, 40 ns clock.
`timescale 1ns/1ps
module tb_filter_out_capture;
    localparam int DATA_W = 24;
    localparam int ADDR_W = 3;
    localparam int LEN    = 8;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } sb_entry_t;

    logic clk = 1'b0;
    logic rst_n;

    filter_out_capture_if #(.DATA_W(DATA_W)) bus ();

    filter_out_capture #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .CAPTURE_LEN (LEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #20 clk = ~clk;

    int                n_checks = 0;
    int                n_errors = 0;
    sb_entry_t         sb_q[$];
    logic [DATA_W-1:0] cap_data [LEN];
    logic [DATA_W-1:0] exp_mem  [LEN];
    int                ridx;
    logic              exp_rd = 1'b0;
    logic              exp_valid_next = 1'b0;
    logic              mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start_capture = 1'b1;
        step();
        bus.start_capture = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    // Writes cap_data with (gap) idle cycles before each valid sample.
    task automatic capture(input int gap);
        for (int i = 0; i < LEN; i++) begin
            repeat (gap) step();
            bus.valid_in = 1'b1;
            bus.data_in  = cap_data[i];
            exp_mem[i]   = cap_data[i];
            step();
            bus.valid_in = 1'b0;
            check("busy_during_capture", 32'(bus.busy), 32'(i < LEN - 1));
            check("done_during_capture", 32'(bus.capture_done), 32'(i == LEN - 1));
        end
        ridx = 0;
    endtask

    task automatic read_one(input int gap);
        sb_entry_t e;
        e.data = exp_mem[ridx];
        e.last = (ridx == LEN - 1);
        sb_q.push_back(e);
        ridx++;
        bus.rd_req = 1'b1;
        exp_rd     = 1'b1;
        step();
        bus.rd_req = 1'b0;
        exp_rd     = 1'b0;
        repeat (gap) step();
    endtask

    task automatic read_all(input int gap);
        while (ridx < LEN) read_one(gap);
        check("done_after_readout", 32'(bus.capture_done), 32'd0);
    endtask

    // Registered-output latency model: a read issued at edge N shows rd_valid after edge N.
    always @(posedge clk) exp_valid_next <= rst_n && exp_rd;

    always @(negedge clk) begin
        if (mon_en) begin
            check("rd_valid", 32'(bus.rd_valid), 32'(exp_valid_next));
            if (bus.rd_valid === 1'b1) begin
                check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    sb_entry_t e;
                    e = sb_q.pop_front();
                    check("rd_data", 32'(bus.rd_data), 32'(e.data));
                    check("rd_last", 32'(bus.rd_last), 32'(e.last));
                end
            end else begin
                check("rd_last_idle", 32'(bus.rd_last), 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n             = 1'b0;
        bus.start_capture = 1'b0;
        bus.data_in       = '0;
        bus.valid_in      = 1'b0;
        bus.rd_req        = 1'b0;
        ridx              = 0;
        repeat (2) step();
        rst_n = 1'b1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.capture_done), 32'd0);
        check("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("reset_rd_data", 32'(bus.rd_data), 32'd0);
        check("reset_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        mon_en = 1'b1;

        // 1: contiguous capture of 1..8, back-to-back readout
        for (int i = 0; i < LEN; i++) cap_data[i] = DATA_W'(i + 1);
        do_start();
        capture(0);
        read_all(0);

        // 2: 1-in-4 valid, signed samples -5..+2
        for (int i = 0; i < LEN; i++) cap_data[i] = DATA_W'(i - 5);
        do_start();
        capture(3);
        read_all(0);

        // 3: drops in IDLE (alone and with start) and in DONE
        bus.valid_in = 1'b1;
        bus.data_in  = DATA_W'(24'hABCDEF);
        step();
        bus.start_capture = 1'b1;
        bus.data_in       = DATA_W'(24'h123456);
        step();
        bus.start_capture = 1'b0;
        bus.valid_in      = 1'b0;
        check("busy_after_start_drop", 32'(bus.busy), 32'd1);
        for (int i = 0; i < LEN; i++) cap_data[i] = DATA_W'(100 + i);
        capture(0);
        bus.valid_in = 1'b1;
        bus.data_in  = DATA_W'(24'h777777);
        step();
        bus.valid_in = 1'b0;
        check("drop_cnt_3", 32'(bus.drop_cnt), 32'd3);
        check("done_holds_after_drop", 32'(bus.capture_done), 32'd1);
        read_all(0);

        // 4: reset after the 4th captured sample aborts the capture
        do_start();
        for (int i = 0; i < 4; i++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = DATA_W'(50 + i);
            step();
        end
        bus.valid_in = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.capture_done), 32'd0);
        check("abort_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        repeat (3) step();
        check("abort_done_later", 32'(bus.capture_done), 32'd0);
        for (int i = 0; i < LEN; i++) cap_data[i] = DATA_W'(60 + i);
        do_start();
        capture(0);
        read_all(0);

        // 5: start_capture with rd_req in DONE after 3 reads
        for (int i = 0; i < LEN; i++) cap_data[i] = DATA_W'(70 + i);
        do_start();
        capture(0);
        repeat (3) read_one(0);
        bus.start_capture = 1'b1;
        bus.rd_req        = 1'b1;
        step();
        bus.start_capture = 1'b0;
        bus.rd_req        = 1'b0;
        check("restart_busy", 32'(bus.busy), 32'd1);
        check("restart_done", 32'(bus.capture_done), 32'd0);
        for (int i = 0; i < LEN; i++) cap_data[i] = DATA_W'(24'h800000 + 80 + i);
        capture(0);
        read_all(0);

        // 6: gapped readout, then rd_req in IDLE is ignored
        for (int i = 0; i < LEN; i++) cap_data[i] = DATA_W'(90 + i);
        do_start();
        capture(0);
        read_all(2);
        bus.rd_req = 1'b1;
        step();
        bus.rd_req = 1'b0;
        repeat (3) step();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("final_drop_cnt", 32'(bus.drop_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
